game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Round sequencer for the tug-of-war game. Drives the 3-bit led_control code consumed by the
//  LED output mux: 000 dark, 001 reset code, 010 all-on, 011 score, 100 fake, 110 speed.
//  Also produces the reaction-time value shown in the speed display, and the scorer
//  push/clear strobes. Sits between the debounced push-button pulses and the scorer/mux.
// PARAMETERS
//  RESET_HOLD   50   ticks the reset code stays displayed after rst
//  DARK_MIN     200  minimum dark-delay ticks; delay = DARK_MIN + rand (0..255)
//  SPEED_HOLD   100  ticks the reaction time stays displayed
//  FAKE_TICKS   30   ticks a fake flash lasts (only with FAKE_ROUND_EN)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  tick         in   1  1-cycle timebase strobe (1 ms)
//  pb_l         in   1  left press, 1-cycle debounced pulse
//  pb_r         in   1  right press, 1-cycle debounced pulse
//  rand         in   8  free-running pseudo-random value
//  winrnd       in   1  scorer level: a player has reached the end of the rope
//  led_control  out  3  display select to LED mux (registered)
//  speed_led    out  7  reaction time in ticks, saturating at 127 (registered)
//  score_en     out  1  1-cycle pulse: count one push for push_side
//  push_side    out  1  0 = left, 1 = right; valid with score_en / false_start
//  false_start  out  1  1-cycle pulse: press before the lights came on
//  round_clr    out  1  level: scorer clear; high only in S_RESET
// BEHAVIOUR
//  Timer: 16-bit down-counter; decrements only on tick; loaded on state entry.
//  Reset (rst=1 at an edge, overrides everything, including mid-round): state S_RESET,
//   led_control=001, round_clr=1, speed_led=0, score_en=0, false_start=0, push_side=0,
//   timer=RESET_HOLD.
//  S_RESET (001): presses ignored; timer hits 0 -> S_WAIT.
//  S_WAIT  (010): first pb_l|pb_r -> S_DARK, timer = DARK_MIN + rand (rand sampled that cycle).
//  S_DARK  (000): a press -> false_start pulse, push_side = the pressing side (left if both)
//   -> S_WAIT. Timer 0 -> S_PLAY, reaction counter cleared.
//   Press and timer-0 in the same cycle: the press wins (false start).
//  S_PLAY  (011): reaction counter +1 per tick, saturating at 127.
//   Single-side press -> score_en=1 for one cycle, push_side=side, speed_led=counter -> S_SPEED.
//   pb_l and pb_r in the same cycle: tie; no score_en; speed_led=counter -> S_SPEED.
//   A press in the same cycle as a tick latches the pre-increment count.
//  S_SPEED (110): timer = SPEED_HOLD; at 0: winrnd=1 -> S_DONE, else -> S_DARK
//   (timer = DARK_MIN + rand). winrnd is sampled only at that exit cycle.
//  S_DONE  (011): final score shown; all inputs ignored until rst.
//  led_control is a registered function of the state, updated in the transition cycle.
//  Latency: press to score_en/led_control change = 1 clk.
//  No unused code (101, 111) is ever driven.
//  Pulses are never asserted for two consecutive cycles.
// CONFIGURATION
//  FAKE_ROUND_EN defined:
//   At S_DARK timer 0, if rand[1:0]==2'b00 -> S_FAKE (100) with timer=FAKE_TICKS, instead of S_PLAY.
//   S_FAKE: a press -> false_start, same as in S_DARK, -> S_WAIT.
//   Timer 0 -> S_DARK with timer = DARK_MIN + rand.
//  FAKE_ROUND_EN undefined: S_FAKE is not built; code 100 is never driven; DARK always -> PLAY.
// TESTING
//  1. rst 1 cycle, RESET_HOLD=50 -> led_control=001 and round_clr=1 for 50 ticks; then 010
//     and round_clr=0.
//  2. WAIT, pb_l, rand=10, DARK_MIN=200 -> 000 for exactly 210 ticks, then 011.
//  3. PLAY, 37 ticks, then pb_r -> next cycle: score_en=1, push_side=1, speed_led=37,
//     led_control=110.
//  4. DARK, press on 5th tick -> false_start=1, push_side=0, led_control=010, no score_en.
//  5. PLAY, pb_l&pb_r same cycle -> no score_en, 110; 200 ticks in PLAY -> speed_led=127.
//  6. SPEED exit with winrnd=1 -> 011 held for 1000 presses/ticks; rst -> 001 next cycle.
//     With FAKE_ROUND_EN and rand[1:0]=0 at dark end -> 100 for 30 ticks, then 000.

Source files
------------

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Round sequencer for the tug-of-war game. Walks each round through
// reset-hold, wait-for-start, random dark delay, reaction play and speed display.
// It drives the LED mux select code, the reaction-time display value and the
// scorer push/clear strobes.
//
// Optional build macro: FAKE_ROUND_EN adds a fake-flash state. When the dark
// delay expires with rand_i[1:0] == 2'b00, the sequencer shows code 100 for
// FAKE_TICKS ticks and then returns to another dark delay.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   tick_i         1-cycle timebase strobe (1 ms)
//   pb_l_i         left press, 1-cycle debounced pulse
//   pb_r_i         right press, 1-cycle debounced pulse
//   rand_i[7:0]    free-running pseudo-random value
//   winrnd_i       scorer level: a player has reached the end of the rope
//   led_control_o  LED mux select (registered)
//   speed_led_o    reaction time in ticks, saturating at 127 (registered)
//   score_en_o     1-cycle pulse: count one push for push_side_o
//   push_side_o    0 = left, 1 = right; valid with score_en_o / false_start_o
//   false_start_o  1-cycle pulse: press before the lights came on
//   round_clr_o    scorer clear level, high only while in the reset state
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int unsigned RESET_HOLD = 50,
    parameter int unsigned DARK_MIN   = 200,
    parameter int unsigned SPEED_HOLD = 100,
    parameter int unsigned FAKE_TICKS = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       pb_l_i,
    input  logic       pb_r_i,
    input  logic [7:0] rand_i,
    input  logic       winrnd_i,
    output logic [2:0] led_control_o,
    output logic [6:0] speed_led_o,
    output logic       score_en_o,
    output logic       push_side_o,
    output logic       false_start_o,
    output logic       round_clr_o
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_WAIT  = 3'd1,
        S_DARK  = 3'd2,
        S_PLAY  = 3'd3,
        S_SPEED = 3'd4,
        S_DONE  = 3'd5
`ifdef FAKE_ROUND_EN
        ,
        S_FAKE  = 3'd6
`endif
    } state_t;

    localparam logic [15:0] RESET_LD = 16'(RESET_HOLD);
    localparam logic [15:0] DARK_LD  = 16'(DARK_MIN);
    localparam logic [15:0] SPEED_LD = 16'(SPEED_HOLD);
`ifdef FAKE_ROUND_EN
    localparam logic [15:0] FAKE_LD  = 16'(FAKE_TICKS);
`endif

    // Display code for a state. Unused codes 101 and 111 never appear.
    function automatic logic [2:0] led_code(input state_t s);
        case (s)
            S_RESET: led_code = 3'b001;
            S_WAIT:  led_code = 3'b010;
            S_DARK:  led_code = 3'b000;
            S_PLAY:  led_code = 3'b011;
            S_SPEED: led_code = 3'b110;
            S_DONE:  led_code = 3'b011;
`ifdef FAKE_ROUND_EN
            S_FAKE:  led_code = 3'b100;
`endif
            default: led_code = 3'b001;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [6:0]  react_q, react_d;
    logic [2:0]  led_q, led_d;
    logic [6:0]  speed_q, speed_d;
    logic        score_q, score_d;
    logic        push_q, push_d;
    logic        fs_q, fs_d;
    logic        clr_q, clr_d;

    logic        press_s;
    logic        both_s;
    logic        timer_zero_s;
    logic [15:0] dark_ld_s;

    assign press_s      = pb_l_i | pb_r_i;
    assign both_s       = pb_l_i & pb_r_i;
    assign timer_zero_s = (timer_q == 16'd0);
    assign dark_ld_s    = DARK_LD + {8'd0, rand_i};

    // Next-state and next-output logic; state loads override the tick decrement.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        push_d  = push_q;
        score_d = 1'b0;
        fs_d    = 1'b0;
        if (tick_i && !timer_zero_s) begin
            timer_d = timer_q - 16'd1;
        end else begin
            timer_d = timer_q;
        end
        if (tick_i && (react_q != 7'd127)) begin
            react_d = react_q + 7'd1;
        end else begin
            react_d = react_q;
        end

        case (state_q)
            S_RESET: begin
                if (timer_zero_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RESET;
                end
            end
            S_WAIT: begin
                if (press_s) begin
                    state_d = S_DARK;
                    timer_d = dark_ld_s;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DARK: begin
                // A press beats an expiring timer in the same cycle.
                if (press_s) begin
                    fs_d    = 1'b1;
                    push_d  = ~pb_l_i;
                    state_d = S_WAIT;
                end else if (timer_zero_s) begin
`ifdef FAKE_ROUND_EN
                    if (rand_i[1:0] == 2'b00) begin
                        state_d = S_FAKE;
                        timer_d = FAKE_LD;
                    end else begin
                        state_d = S_PLAY;
                        react_d = 7'd0;
                    end
`else
                    state_d = S_PLAY;
                    react_d = 7'd0;
`endif
                end else begin
                    state_d = S_DARK;
                end
            end
            S_PLAY: begin
                // The latched time is the count before this cycle's tick.
                if (press_s) begin
                    speed_d = react_q;
                    state_d = S_SPEED;
                    timer_d = SPEED_LD;
                    if (!both_s) begin
                        score_d = 1'b1;
                        push_d  = pb_r_i;
                    end else begin
                        score_d = 1'b0;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_SPEED: begin
                if (timer_zero_s) begin
                    if (winrnd_i) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DARK;
                        timer_d = dark_ld_s;
                    end
                end else begin
                    state_d = S_SPEED;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
`ifdef FAKE_ROUND_EN
            S_FAKE: begin
                if (press_s) begin
                    fs_d    = 1'b1;
                    push_d  = ~pb_l_i;
                    state_d = S_WAIT;
                end else if (timer_zero_s) begin
                    state_d = S_DARK;
                    timer_d = dark_ld_s;
                end else begin
                    state_d = S_FAKE;
                end
            end
`endif
            default: begin
                state_d = S_RESET;
                timer_d = RESET_LD;
            end
        endcase

        led_d = led_code(state_d);
        clr_d = (state_d == S_RESET);
    end

    // State, timer, reaction counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RESET;
            timer_q <= RESET_LD;
            react_q <= 7'd0;
            led_q   <= 3'b001;
            speed_q <= 7'd0;
            score_q <= 1'b0;
            push_q  <= 1'b0;
            fs_q    <= 1'b0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            react_q <= react_d;
            led_q   <= led_d;
            speed_q <= speed_d;
            score_q <= score_d;
            push_q  <= push_d;
            fs_q    <= fs_d;
            clr_q   <= clr_d;
        end
    end

    assign led_control_o = led_q;
    assign speed_led_o   = speed_q;
    assign score_en_o    = score_q;
    assign push_side_o   = push_q;
    assign false_start_o = fs_q;
    assign round_clr_o   = clr_q;

endmodule
